// File: rtl/fp_add_sequencer.sv
// Control sequencer for the multi-cycle single-precision FP adder datapath.
// Walks IDLE->ALIGN->ADD->NORM->CHECK->DONE and reports result status via valid/ready.
module fp_add_sequencer #(
   parameter int MANTISSA_N = 25,
   parameter int EXP_N      = 8,
   parameter int SHIFT_W    = $clog2(MANTISSA_N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_N:0]       exp_diff,
   input  logic                 sum_carry,
   input  logic                 sum_zero,
   input  logic [EXP_N+1:0]     norm_exp,
   output logic                 load_ops,
   output logic                 swap_ops,
   output logic [SHIFT_W-1:0]   align_shift,
   output logic                 load_align,
   output logic                 load_sum,
   output logic                 shift_right,
   output logic                 load_norm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 res_zero,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 busy
);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, CHECK, DONE} state_t;

   localparam logic [EXP_N:0]          MANT_LIM = (EXP_N+1)'(MANTISSA_N);
   localparam logic [SHIFT_W-1:0]      SHIFT_MAX = SHIFT_W'(MANTISSA_N);
   localparam logic signed [EXP_N+1:0] EXP_MAX  = (EXP_N+2)'((1 << EXP_N) - 1);
   localparam logic signed [EXP_N+1:0] EXP_MIN  = (EXP_N+2)'(1);

   state_t             state;
   logic [EXP_N:0]     diff_mag;
   logic [SHIFT_W-1:0] shift_sat;
   logic               ovf_c, unf_c;

   // Magnitude is unsigned at EXP_N+1 bits so the most negative difference still saturates.
   always_comb begin
      diff_mag  = exp_diff[EXP_N] ? (~exp_diff + 1'b1) : exp_diff;
      shift_sat = (diff_mag >= MANT_LIM) ? SHIFT_MAX : diff_mag[SHIFT_W-1:0];
      ovf_c     = $signed(norm_exp) >= EXP_MAX;
      unf_c     = $signed(norm_exp) < EXP_MIN;
   end

   // Strobes are pure state decodes; load_ops is the accept handshake itself.
   assign load_ops    = (state == IDLE) && in_valid;
   assign load_align  = (state == ALIGN);
   assign load_sum    = (state == ADD);
   assign load_norm   = (state == NORM);
   assign shift_right = (state == NORM) && sum_carry;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         busy        <= 1'b0;
         swap_ops    <= 1'b0;
         align_shift <= '0;
         out_valid   <= 1'b0;
         res_zero    <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               state    <= ALIGN;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
            ALIGN: begin
               swap_ops    <= exp_diff[EXP_N];
               align_shift <= shift_sat;
               state       <= ADD;
            end
            ADD: state <= NORM;
            NORM: if (sum_zero) begin
               res_zero  <= 1'b1;
               out_valid <= 1'b1;
               state     <= DONE;
            end else begin
               state <= CHECK;
            end
            CHECK: begin
               overflow  <= ovf_c;
               underflow <= unf_c;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid   <= 1'b0;
               res_zero    <= 1'b0;
               overflow    <= 1'b0;
               underflow   <= 1'b0;
               swap_ops    <= 1'b0;
               align_shift <= '0;
               in_ready    <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: walks each operation state by state.
module tb_fp_add_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, sum_carry, sum_zero;
   logic [8:0] exp_diff;
   logic [9:0] norm_exp;
   logic       load_ops, swap_ops, load_align, load_sum, shift_right, load_norm;
   logic [4:0] align_shift;
   logic       out_valid, out_ready, res_zero, overflow, underflow, busy;
   int         total = 0, bad = 0;

   always #5 clk = ~clk;

   fp_add_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .exp_diff(exp_diff), .sum_carry(sum_carry), .sum_zero(sum_zero), .norm_exp(norm_exp),
      .load_ops(load_ops), .swap_ops(swap_ops), .align_shift(align_shift),
      .load_align(load_align), .load_sum(load_sum), .shift_right(shift_right),
      .load_norm(load_norm), .out_valid(out_valid), .out_ready(out_ready),
      .res_zero(res_zero), .overflow(overflow), .underflow(underflow), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Strobe vector {load_ops, load_align, load_sum, load_norm}
   function automatic logic [3:0] strobes();
      return {load_ops, load_align, load_sum, load_norm};
   endfunction

   // One operation; checks made at negedge in each state. hold = DONE cycles with out_ready=0.
   task automatic run_op(input int ed, input bit carry, input bit zero, input int nexp,
                         input bit e_swap, input int e_shift, input bit e_ov, input bit e_un,
                         input int hold);
      exp_diff  = 9'(ed);
      sum_carry = carry;
      sum_zero  = zero;
      norm_exp  = 10'(nexp);
      in_valid  = 1'b1;
      #1;
      chk("idle_load_ops", 32'(strobes()), 32'b1000);
      chk("idle_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("align_strobes", 32'(strobes()), 32'b0100);
      chk("align_busy", 32'({busy, in_ready}), 32'b10);
      @(negedge clk);
      chk("add_strobes", 32'(strobes()), 32'b0010);
      chk("add_swap", 32'(swap_ops), 32'(e_swap));
      chk("add_shift", 32'(align_shift), 32'(e_shift));
      @(negedge clk);
      chk("norm_strobes", 32'(strobes()), 32'b0001);
      chk("norm_shift_right", 32'(shift_right), 32'(carry));
      chk("norm_out_valid", 32'(out_valid), 0);
      if (!zero) begin
         @(negedge clk);
         chk("check_strobes", 32'({strobes(), shift_right}), 0);
         chk("check_out_valid", 32'(out_valid), 0);
      end
      @(negedge clk);
      chk("done_out_valid", 32'(out_valid), 1);
      chk("done_flags", 32'({res_zero, overflow, underflow}), 32'({zero, e_ov, e_un}));
      chk("done_hold_cfg", 32'({swap_ops, align_shift}), 32'({e_swap, 5'(e_shift)}));
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_in_ready", 32'({in_ready, load_ops}), 0);
         chk("bp_flags", 32'({res_zero, overflow, underflow}), 32'({zero, e_ov, e_un}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("ret_idle", 32'({in_ready, busy, out_valid}), 32'b100);
      chk("ret_cleared", 32'({res_zero, overflow, underflow, swap_ops, align_shift}), 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      exp_diff = '0; sum_carry = 1'b0; sum_zero = 1'b0; norm_exp = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_outs", 32'({busy, out_valid, res_zero, overflow, underflow, swap_ops,
                            align_shift, strobes(), shift_right}), 0);
      rst_n = 1'b1;
      out_ready = 1'b1;  // out_ready outside DONE must be harmless
      @(negedge clk);
      chk("idle_out_ready_noeffect", 32'({in_ready, busy, out_valid}), 32'b100);
      out_ready = 1'b0;

      // exp_diff, carry, zero, norm_exp, swap, shift, ovf, unf, hold
      run_op(   3, 0, 0,  130, 0,  3, 0, 0, 0);
      run_op( -40, 1, 0,  131, 1, 25, 0, 0, 0);
      run_op(   5, 0, 1,    0, 0,  5, 0, 0, 0);
      run_op(   0, 1, 0,  255, 0,  0, 1, 0, 0);
      run_op(  -1, 0, 0,    0, 1,  1, 0, 1, 0);
      run_op(  24, 0, 0,   -3, 0, 24, 0, 1, 0);
      run_op(  25, 0, 0,  254, 0, 25, 0, 0, 0);
      run_op(-256, 0, 0,    1, 1, 25, 0, 0, 0);
      run_op( 255, 1, 0,  300, 0, 25, 1, 0, 5);

      // Abort in ADD: sequencer returns to IDLE and never raises out_valid.
      exp_diff = 9'd2; norm_exp = 10'd100; sum_zero = 1'b0; sum_carry = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("abort_in_add", 32'(load_sum), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_idle", 32'({in_ready, busy}), 32'b10);
      chk("abort_outs", 32'({strobes(), shift_right, out_valid, swap_ops, align_shift}), 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_valid", 32'({out_valid, busy}), 0);
      end

      run_op(  -7, 0, 0,  127, 1,  7, 0, 0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
